sdram_write_arbiter: RTL and testbench
======================================

# sdram_write_arbiter

Shares the single FPGA-to-HPS SDRAM write port (f2h_sdram1, Avalon-MM write master side) between two write masters: the background-fill engine (m0) and the rasteriser pixel writer (m1). Grants whole bursts, never splitting one, and arbitrates round-robin at burst boundaries. An optional priority override favours m0. It sits between the framebuffer write path and the soc_system sdram1 port.

## Interface
Parameters:
- ADDR_WIDTH, 29, Avalon word address width.
- DATA_WIDTH, 64, write data width; BE_WIDTH = DATA_WIDTH/8 (derived, not overridable).
- BURST_WIDTH, 8, burstcount width.

Ports:
- clock  in  1  system clock (50 MHz domain); one clock only.
- reset_n  in  1  asynchronous, active-low reset.
- m0_address / m1_address  in  ADDR_WIDTH  master write address, valid on first beat.
- m0_burstcount / m1_burstcount  in  BURST_WIDTH  beats in burst, sampled on first beat.
- m0_writedata / m1_writedata  in  DATA_WIDTH  beat data.
- m0_byteenable / m1_byteenable  in  BE_WIDTH  beat byte enables.
- m0_write / m1_write  in  1  beat request.
- m0_waitrequest / m1_waitrequest  out  1  stall to master.
- s_address  out  ADDR_WIDTH  to sdram1.
- s_burstcount  out  BURST_WIDTH  to sdram1.
- s_writedata  out  DATA_WIDTH  to sdram1.
- s_byteenable  out  BE_WIDTH  to sdram1.
- s_write  out  1  to sdram1.
- s_waitrequest  in  1  from sdram1.
- m0_priority  in  1  1 = m0 wins every contended arbitration.
- grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 0 when idle.
- busy  out  1  high while a burst is in progress.

## Operation
- States: IDLE, BURST_M0, BURST_M1. Registers: state, beats_left (BURST_WIDTH), last_owner (1 bit).
- IDLE: both m*_waitrequest = 1; s_write = 0; s_* data/address/burstcount/byteenable = 0.
- IDLE arbitration on m0_write / m1_write:
  - only one asserted -> that master's BURST state.
  - both asserted, m0_priority = 1 -> BURST_M0.
  - both asserted, m0_priority = 0 -> the master that is not last_owner.
  - neither -> stay in IDLE.
- On entry to BURST_Mx: last_owner <= x; beats_left <= mx_burstcount, with 0 treated as 1.
- BURST_Mx: s_* combinationally mirrors mx_*; mx_waitrequest = s_waitrequest; the other master's waitrequest = 1.
- Accepted beat = s_write & ~s_waitrequest; each accepted beat decrements beats_left.
- On the accepted beat with beats_left == 1 -> IDLE.
- Master write deasserted mid-burst (Avalon violation): arbiter keeps grant, counts nothing, waits.
- grant is one-hot from state; busy = (state != IDLE).
- Reset (async, any state): state = IDLE, beats_left = 0, last_owner = 1 (so m0 wins the first contention). All outputs take IDLE values immediately, including mid-burst.

## Timing
- Arbitration latency: master asserts write in cycle N while IDLE -> BURST in N+1. s_write first asserted in N+1; waitrequest to the master is 1 in N.
- A burst of B beats with no slave stall occupies B cycles in BURST.
- End of burst returns to IDLE for exactly one cycle, so back-to-back bursts cost 1 dead cycle. The next grant is decided in that IDLE cycle.
- Master outputs to s_* and s_waitrequest to master waitrequest are purely combinational (zero latency) in BURST states. No other combinational paths.
- Slave-side burstcount is forwarded on every beat; the sdram1 port samples it on the first beat only.

## Test plan
- Single burst: m0 write, burstcount=4, s_waitrequest=0 -> s_write high for cycles N+1..N+4, data forwarded in order, grant=01, then IDLE at N+5; m1_waitrequest=1 throughout.
- Contention round-robin: both request bursts of 2 continuously, m0_priority=0 -> grant sequence m0,m1,m0,m1 after reset, with 1 idle cycle between each.
- Priority: m0_priority=1, both requesting continuously with burstcount=1 -> every grant to m0; m1 starves until m0_write drops, then granted next IDLE.
- Slave stall: m1 burst of 3, s_waitrequest high for 2 cycles on beat 2 -> m1_waitrequest mirrors it, beat 2 data held, exactly 3 accepted beats, IDLE after the third.
- burstcount=0: m0 write with burstcount 0 -> treated as 1 beat, IDLE after first accepted beat.
- Reset mid-burst: assert reset_n=0 on beat 3 of an 8-beat m1 burst -> s_write=0, grant=0, busy=0 immediately (same cycle, asynchronous). After release, a simultaneous request is granted to m0.

Source files
------------

// File: rtl/sdram_write_arbiter.sv
// Burst-granular round-robin arbiter sharing the f2h_sdram1 Avalon-MM write port
// between the background-fill engine (m0) and the rasteriser pixel writer (m1).
module sdram_write_arbiter #(
   parameter int ADDR_WIDTH  = 29,
   parameter int DATA_WIDTH  = 64,
   parameter int BURST_WIDTH = 8
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [ADDR_WIDTH-1:0]     m0_address,
   input  logic [BURST_WIDTH-1:0]    m0_burstcount,
   input  logic [DATA_WIDTH-1:0]     m0_writedata,
   input  logic [DATA_WIDTH/8-1:0]   m0_byteenable,
   input  logic                      m0_write,
   output logic                      m0_waitrequest,
   input  logic [ADDR_WIDTH-1:0]     m1_address,
   input  logic [BURST_WIDTH-1:0]    m1_burstcount,
   input  logic [DATA_WIDTH-1:0]     m1_writedata,
   input  logic [DATA_WIDTH/8-1:0]   m1_byteenable,
   input  logic                      m1_write,
   output logic                      m1_waitrequest,
   output logic [ADDR_WIDTH-1:0]     s_address,
   output logic [BURST_WIDTH-1:0]    s_burstcount,
   output logic [DATA_WIDTH-1:0]     s_writedata,
   output logic [DATA_WIDTH/8-1:0]   s_byteenable,
   output logic                      s_write,
   input  logic                      s_waitrequest,
   input  logic                      m0_priority,
   output logic [1:0]                grant,
   output logic                      busy
);

   localparam logic [BURST_WIDTH-1:0] ONE_BEAT = BURST_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BURST_M0 = 2'd1,
      BURST_M1 = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [BURST_WIDTH-1:0]   beats_left_q, beats_left_d;
   logic                     last_owner_q, last_owner_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         beats_left_q <= '0;
         last_owner_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         beats_left_q <= beats_left_d;
         last_owner_q <= last_owner_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      beats_left_d   = beats_left_q;
      last_owner_d   = last_owner_q;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      s_address      = '0;
      s_burstcount   = '0;
      s_writedata    = '0;
      s_byteenable   = '0;
      s_write        = 1'b0;
      grant          = 2'b00;
      busy           = 1'b0;

      case (state_q)
         IDLE: begin
            // m0 takes contention when prioritised or when m1 owned the last burst
            if (m0_write && (!m1_write || m0_priority || last_owner_q)) begin
               state_d      = BURST_M0;
               last_owner_d = 1'b0;
               beats_left_d = (m0_burstcount == '0) ? ONE_BEAT : m0_burstcount;
            end else if (m1_write) begin
               state_d      = BURST_M1;
               last_owner_d = 1'b1;
               beats_left_d = (m1_burstcount == '0) ? ONE_BEAT : m1_burstcount;
            end
         end

         BURST_M0: begin
            grant          = 2'b01;
            busy           = 1'b1;
            s_address      = m0_address;
            s_burstcount   = m0_burstcount;
            s_writedata    = m0_writedata;
            s_byteenable   = m0_byteenable;
            s_write        = m0_write;
            m0_waitrequest = s_waitrequest;
            if (m0_write && !s_waitrequest) begin
               beats_left_d = beats_left_q - ONE_BEAT;
               if (beats_left_q == ONE_BEAT) state_d = IDLE;
            end
         end

         BURST_M1: begin
            grant          = 2'b10;
            busy           = 1'b1;
            s_address      = m1_address;
            s_burstcount   = m1_burstcount;
            s_writedata    = m1_writedata;
            s_byteenable   = m1_byteenable;
            s_write        = m1_write;
            m1_waitrequest = s_waitrequest;
            if (m1_write && !s_waitrequest) begin
               beats_left_d = beats_left_q - ONE_BEAT;
               if (beats_left_q == ONE_BEAT) state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sdram_write_arbiter.sv
// Directed bench for sdram_write_arbiter: master drivers issue bursts, a scoreboard
// queue holds the expected slave-side beats and a negedge monitor checks them.
module tb_sdram_write_arbiter;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic [28:0]  m0_address = '0, m1_address = '0;
   logic [7:0]   m0_burstcount = '0, m1_burstcount = '0;
   logic [63:0]  m0_writedata = '0, m1_writedata = '0;
   logic [7:0]   m0_byteenable = '0, m1_byteenable = '0;
   logic         m0_write = 1'b0, m1_write = 1'b0;
   logic         m0_waitrequest, m1_waitrequest;
   logic [28:0]  s_address;
   logic [7:0]   s_burstcount;
   logic [63:0]  s_writedata;
   logic [7:0]   s_byteenable;
   logic         s_write;
   logic         s_waitrequest = 1'b0;
   logic         m0_priority = 1'b0;
   logic [1:0]   grant;
   logic         busy;

   sdram_write_arbiter #(.ADDR_WIDTH(29), .DATA_WIDTH(64), .BURST_WIDTH(8)) dut (
      .clock(clock), .reset_n(reset_n),
      .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_writedata(m0_writedata),
      .m0_byteenable(m0_byteenable), .m0_write(m0_write), .m0_waitrequest(m0_waitrequest),
      .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_writedata(m1_writedata),
      .m1_byteenable(m1_byteenable), .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
      .s_address(s_address), .s_burstcount(s_burstcount), .s_writedata(s_writedata),
      .s_byteenable(s_byteenable), .s_write(s_write), .s_waitrequest(s_waitrequest),
      .m0_priority(m0_priority), .grant(grant), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0]  g;
      logic [28:0] addr;
      logic [7:0]  bc;
      logic [63:0] data;
      logic [7:0]  be;
   } beat_t;

   beat_t exp_q[$];
   int    n_vec = 0;
   int    n_miss = 0;
   int    cyc = 0;
   int    last_acc = -1;
   int    c0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted slave beat must match the head of the queue
   always @(negedge clock) begin
      if (s_write === 1'b1 && s_waitrequest === 1'b0) begin
         last_acc = cyc;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_beat: got addr %h data %h grant %b, expected no beat",
                     s_address, s_writedata, grant);
         end else begin
            beat_t e;
            beat_t a;
            e = exp_q.pop_front();
            a = '{g: grant, addr: s_address, bc: s_burstcount, data: s_writedata, be: s_byteenable};
            chk("beat", 128'(a), 128'(e));
         end
      end
   end

   function automatic logic [7:0] be_of(input logic [63:0] d);
      return ~d[7:0];
   endfunction

   task automatic expect_burst(input logic [1:0] g, input logic [28:0] addr,
                               input logic [7:0] bc, input logic [63:0] base);
      int n;
      n = (bc == 8'd0) ? 1 : int'(bc);
      for (int j = 0; j < n; j++)
         exp_q.push_back('{g: g, addr: addr, bc: bc, data: base + 64'(j), be: be_of(base + 64'(j))});
   endtask

   task automatic set_beat(input int m, input logic wr, input logic [28:0] addr,
                           input logic [7:0] bc, input logic [63:0] d);
      if (m == 0) begin
         m0_write = wr; m0_address = addr; m0_burstcount = bc;
         m0_writedata = d; m0_byteenable = be_of(d);
      end else begin
         m1_write = wr; m1_address = addr; m1_burstcount = bc;
         m1_writedata = d; m1_byteenable = be_of(d);
      end
   endtask

   // Avalon burst master: holds each beat until it sees waitrequest low at a negedge
   task automatic drive(input int m, input logic [28:0] addr, input logic [7:0] bc,
                        input logic [63:0] base);
      int n;
      int j;
      logic acc;
      n = (bc == 8'd0) ? 1 : int'(bc);
      j = 0;
      set_beat(m, 1'b1, addr, bc, base);
      while (j < n) begin
         @(negedge clock);
         acc = (m == 0) ? !m0_waitrequest : !m1_waitrequest;
         @(posedge clock); #1;
         if (acc) begin
            j++;
            if (j < n) set_beat(m, 1'b1, addr, bc, base + 64'(j));
         end
      end
      set_beat(m, 1'b0, '0, '0, '0);
   endtask

   task automatic pulse_reset();
      @(posedge clock); #1;
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   task automatic idle_gap();
      repeat (3) @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no completion, expected summary before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clock);
      #2;
      chk("rst_grant", 128'(grant), 128'(2'b00));
      chk("rst_busy", 128'(busy), 128'(1'b0));
      chk("rst_swrite", 128'(s_write), 128'(1'b0));
      chk("rst_wait", 128'({m0_waitrequest, m1_waitrequest}), 128'(2'b11));
      chk("rst_addr", 128'(s_address), 128'(29'd0));
      #1 reset_n = 1'b1;
      idle_gap();

      // Single m0 burst of 4
      expect_burst(2'b01, 29'h100, 8'd4, 64'hA000);
      c0 = cyc;
      fork
         drive(0, 29'h100, 8'd4, 64'hA000);
         begin
            @(negedge clock);
            chk("t1_wait_N", 128'(m0_waitrequest), 128'(1'b1));
            chk("t1_busy_N", 128'(busy), 128'(1'b0));
            for (int k = 0; k < 4; k++) begin
               @(negedge clock);
               chk("t1_grant", 128'({grant, s_write, m1_waitrequest}), 128'(4'b0111));
            end
            @(negedge clock);
            chk("t1_idle", 128'({grant, busy}), 128'(3'b000));
         end
      join
      chk("t1_last", 128'(last_acc), 128'(c0 + 4));
      chk("t1_q", 128'(exp_q.size()), 128'(0));

      // Round-robin contention after reset
      pulse_reset();
      idle_gap();
      expect_burst(2'b01, 29'h200, 8'd2, 64'hB000);
      expect_burst(2'b10, 29'h300, 8'd2, 64'hC000);
      expect_burst(2'b01, 29'h210, 8'd2, 64'hB100);
      expect_burst(2'b10, 29'h310, 8'd2, 64'hC100);
      c0 = cyc;
      fork
         begin drive(0, 29'h200, 8'd2, 64'hB000); drive(0, 29'h210, 8'd2, 64'hB100); end
         begin drive(1, 29'h300, 8'd2, 64'hC000); drive(1, 29'h310, 8'd2, 64'hC100); end
      join
      chk("t2_last", 128'(last_acc), 128'(c0 + 11));
      chk("t2_q", 128'(exp_q.size()), 128'(0));
      idle_gap();

      // Priority override: m1 starves until m0 stops requesting
      m0_priority = 1'b1;
      expect_burst(2'b01, 29'h400, 8'd1, 64'hD000);
      expect_burst(2'b01, 29'h401, 8'd1, 64'hD100);
      expect_burst(2'b01, 29'h402, 8'd1, 64'hD200);
      expect_burst(2'b10, 29'h500, 8'd1, 64'hE000);
      c0 = cyc;
      fork
         begin
            drive(0, 29'h400, 8'd1, 64'hD000);
            drive(0, 29'h401, 8'd1, 64'hD100);
            drive(0, 29'h402, 8'd1, 64'hD200);
         end
         drive(1, 29'h500, 8'd1, 64'hE000);
      join
      chk("t3_last", 128'(last_acc), 128'(c0 + 7));
      chk("t3_q", 128'(exp_q.size()), 128'(0));
      m0_priority = 1'b0;
      idle_gap();

      // Slave stall of two cycles on beat 2 of an m1 burst of 3
      expect_burst(2'b10, 29'h600, 8'd3, 64'hF000);
      c0 = cyc;
      fork
         drive(1, 29'h600, 8'd3, 64'hF000);
         begin
            repeat (2) begin @(posedge clock); #1; end
            s_waitrequest = 1'b1;
            @(negedge clock);
            chk("t4_stall1", 128'({m1_waitrequest, s_writedata}), 128'({1'b1, 64'hF001}));
            @(posedge clock); #1;
            @(negedge clock);
            chk("t4_stall2", 128'({m1_waitrequest, s_writedata}), 128'({1'b1, 64'hF001}));
            @(posedge clock); #1;
            s_waitrequest = 1'b0;
         end
      join
      @(negedge clock);
      chk("t4_idle", 128'(busy), 128'(1'b0));
      chk("t4_last", 128'(last_acc), 128'(c0 + 5));
      chk("t4_q", 128'(exp_q.size()), 128'(0));
      idle_gap();

      // burstcount 0 behaves as a single beat
      expect_burst(2'b01, 29'h700, 8'd0, 64'h1234);
      c0 = cyc;
      drive(0, 29'h700, 8'd0, 64'h1234);
      @(negedge clock);
      chk("t5_idle", 128'({busy, grant}), 128'(3'b000));
      chk("t5_last", 128'(last_acc), 128'(c0 + 1));
      chk("t5_q", 128'(exp_q.size()), 128'(0));
      idle_gap();

      // Asynchronous reset on beat 3 of an 8-beat m1 burst
      expect_burst(2'b10, 29'h800, 8'd2, 64'h9000);
      set_beat(1, 1'b1, 29'h800, 8'd8, 64'h9000);
      exp_q[0].bc = 8'd8;
      exp_q[1].bc = 8'd8;
      @(posedge clock); #1;
      @(posedge clock); #1;
      set_beat(1, 1'b1, 29'h800, 8'd8, 64'h9001);
      @(posedge clock); #1;
      set_beat(1, 1'b1, 29'h800, 8'd8, 64'h9002);
      #1 reset_n = 1'b0;
      #1;
      chk("t6_async", 128'({s_write, grant, busy, m1_waitrequest}), 128'(5'b00001));
      set_beat(1, 1'b0, '0, '0, '0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      chk("t6_q", 128'(exp_q.size()), 128'(0));
      expect_burst(2'b01, 29'h900, 8'd1, 64'h7000);
      expect_burst(2'b10, 29'hA00, 8'd1, 64'h8000);
      fork
         drive(0, 29'h900, 8'd1, 64'h7000);
         drive(1, 29'hA00, 8'd1, 64'h8000);
      join
      chk("t6_post_q", 128'(exp_q.size()), 128'(0));
      idle_gap();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
